// File: rtl/serial_pkg.sv
// Shared definitions for the serial operand transmitter: FSM state encoding,
// default operand width and the frame-length helper.
// Optional feature macro: SERIAL_TX_PARITY_EN (appends an even-parity bit).
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        KICK  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int DEFAULT_N = 4;

    // Number of SHIFT cycles in one frame for an operand width of n bits.
    function automatic int frame_len(input int n);
`ifdef SERIAL_TX_PARITY_EN
        return 2 * n + 1;
`else
        return 2 * n;
`endif
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register. Load has priority over shift.
// Shifts right, filling with zero, so bit 0 always holds the next bit out.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q0
);

    logic [W-1:0] r_q;

    // Register load/shift with asynchronous clear on active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (shift) begin
            r_q <= {1'b0, r_q[W-1:1]};
        end
    end

    assign q0 = r_q[0];

endmodule

// File: rtl/serial_operand_tx.sv
// Serial operand transmitter: captures {b,a} on an accepted start and sends
// it LSB first (A then B) to a serial adder, framed by a tx_start pulse
// before the data and a done pulse after it.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds a trailing even-parity bit).
//
// Output protocol: tx_start is a one-cycle pulse in the cycle before the first
// data bit. so_valid qualifies so; it is high for exactly FRAME consecutive
// cycles and so is 0 whenever so_valid is low. There is no back-pressure: the
// downstream adder must accept one bit per cycle while so_valid is high.
// done pulses for one cycle after the last bit. start is only sampled in IDLE;
// a start seen while busy is dropped, not queued.
module serial_operand_tx
    import serial_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         tx_start,
    output logic         so,
    output logic         so_valid,
    output logic         busy,
    output logic         done,
    output state_t       o_dbg_state
);

    localparam int            FRAME = frame_len(N);
    // Sized for 2N+2 so the post-increment value after the last bit never wraps.
    localparam int            CW    = $clog2(2 * N + 2);
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          w_load;
    logic          w_shift;
    logic          w_last;
    logic          w_q0;

    assign w_load  = (r_state == IDLE) && start;
    assign w_shift = (r_state == SHIFT);
    assign w_last  = w_shift && (r_cnt == LAST);

    piso_shift_reg #(
        .W (2 * N)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .shift (w_shift),
        .d     ({b, a}),
        .q0    (w_q0)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = KICK;
            KICK:                w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:                w_next = IDLE;
            default:             w_next = IDLE;
        endcase
    end

    // Bit counter: cleared on accept, advances once per SHIFT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    logic r_parity;

    // Even parity of the captured operands, emitted as the final frame bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^{b, a};
        end
    end
`endif

    // Moore outputs decoded from the current state.
    always_comb begin
        tx_start = 1'b0;
        so       = 1'b0;
        so_valid = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            IDLE: busy = 1'b0;
            KICK: tx_start = 1'b1;
            SHIFT: begin
                so_valid = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                so = w_last ? r_parity : w_q0;
`else
                so = w_q0;
`endif
            end
            DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_operand_tx.sv
// Bench for serial_operand_tx: a timeline reference model predicts, for each
// accepted start, the tx_start cycle, the ordered frame bits and the done
// cycle; a negedge monitor pops and compares whatever the DUT presents.
module tb_serial_operand_tx;
    import serial_pkg::*;

    localparam int N = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME = 2 * N + 1;
`else
    localparam int FRAME = 2 * N;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         tx_start;
    logic         so;
    logic         so_valid;
    logic         busy;
    logic         done;
    state_t       dbg_state;

    int n_cmp     = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int idle_from = 0;
    int busy_lo   = 1;
    int busy_hi   = 0;

    logic [0:0]     exp_q[$];
    int             kick_q[$];
    int             done_q[$];
    logic [2*N-1:0] cap     = '0;
    int             cap_idx = 0;
    logic           last_so = 1'b0;

    serial_operand_tx #(.N(N)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .tx_start    (tx_start),
        .so          (so),
        .so_valid    (so_valid),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // A start seen at the edge ending cycle c, while the block is free, yields
    // tx_start in c+1, bits in c+2..c+1+FRAME, done in c+2+FRAME, and the
    // block is free to accept again at the edge ending c+3+FRAME.
    always @(posedge clk) begin
        if (!rst_n) begin
            idle_from = cyc + 1;
        end else if (start && cyc >= idle_from) begin
            for (int i = 0; i < N; i++) exp_q.push_back(a[i]);
            for (int i = 0; i < N; i++) exp_q.push_back(b[i]);
`ifdef SERIAL_TX_PARITY_EN
            exp_q.push_back(^{a, b});
`endif
            kick_q.push_back(cyc + 1);
            done_q.push_back(cyc + 2 + FRAME);
            busy_lo   = cyc + 1;
            busy_hi   = cyc + 2 + FRAME;
            idle_from = cyc + 3 + FRAME;
        end
        cyc++;
    end

    // Reset aborts the frame in flight: nothing already predicted may appear.
    always @(negedge rst_n) begin
        exp_q.delete();
        kick_q.delete();
        done_q.delete();
        busy_lo = 1;
        busy_hi = 0;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        if (tx_start) begin
            cap_idx = 0;
            if (kick_q.size() == 0) report_unexpected("tx_start");
            else check("tx_start_cycle", cyc, kick_q.pop_front());
        end
        if (done) begin
            if (done_q.size() == 0) report_unexpected("done");
            else check("done_cycle", cyc, done_q.pop_front());
        end
        if (so_valid) begin
            if (exp_q.size() == 0) report_unexpected("so_bit");
            else check("so_bit", 32'(so), 32'(exp_q.pop_front()));
            if (cap_idx < 2 * N) cap[cap_idx] = so;
            cap_idx++;
            last_so = so;
        end else begin
            check("so_idle_zero", 32'(so), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_so"},       32'(so),       32'd0);
        check({tag, "_so_valid"}, 32'(so_valid), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [2*N-1:0] ref_frame;
        ref_frame = {4'b0101, 4'b0011};

        // Reset state.
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Directed frame a=0011, b=0101: so = 1,1,0,0,1,0,1,0.
        send(4'b0011, 4'b0101);
        repeat (FRAME + 3) tick();
        check("directed_frame", 32'(cap), 32'(ref_frame));

        // Boundary operands.
        send(4'hF, 4'h1);
        repeat (FRAME + 3) tick();
        send(4'h0, 4'h0);
        repeat (FRAME + 3) tick();
        send(4'hF, 4'hF);
        repeat (FRAME + 3) tick();

`ifdef SERIAL_TX_PARITY_EN
        send(4'b0111, 4'b0001);
        repeat (FRAME + 3) tick();
        check("parity_even_bit", 32'(last_so), 32'd0);
        send(4'b0011, 4'b0001);
        repeat (FRAME + 3) tick();
        check("parity_odd_bit", 32'(last_so), 32'd1);
`endif

        // Start pulsed in the 4th SHIFT cycle with new operands: ignored.
        send(N'($urandom), N'($urandom));
        repeat (4) tick();
        a     = N'($urandom);
        b     = N'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (FRAME + 3) tick();

        // Start held high: back-to-back frames, operands changing every cycle.
        start = 1'b1;
        for (int k = 0; k < 3 * (FRAME + 3) + 1; k++) begin
            a = N'($urandom);
            b = N'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (FRAME + 4) tick();

        // Reset during SHIFT bit 3, then a fresh directed frame.
        send(N'($urandom), N'($urandom));
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(4'b0011, 4'b0101);
        repeat (FRAME + 3) tick();
        check("post_reset_frame", 32'(cap), 32'(ref_frame));

        // Random traffic.
        for (int k = 0; k < 120; k++) begin
            start = ($urandom_range(0, 3) == 0);
            a     = N'($urandom);
            b     = N'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (2 * FRAME + 6) tick();

        // Everything predicted must have been observed.
        check("exp_bits_left",  32'(exp_q.size()),  32'd0);
        check("exp_kicks_left", 32'(kick_q.size()), 32'd0);
        check("exp_dones_left", 32'(done_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
